// File: rtl/nanorv32_datamem_responder_pkg.sv
// rtl/nanorv32_datamem_responder_pkg.sv - shared widths and FSM encoding for the data memory responder
package nanorv32_datamem_responder_pkg;

    localparam int NANORV32_DATA_MSB = 31;
    localparam int NANORV32_ADDR_MSB = 31;
    localparam int NANORV32_DMEM_CNT_W = 4;

    typedef enum logic [1:0] {
        NANORV32_DMEM_STATE_IDLE   = 2'd0,
        NANORV32_DMEM_STATE_WAIT   = 2'd1,
        NANORV32_DMEM_STATE_ACCESS = 2'd2,
        NANORV32_DMEM_STATE_ACK    = 2'd3
    } nanorv32_dmem_state_t;

endpackage

// File: rtl/nanorv32_sram_1p.sv
// rtl/nanorv32_sram_1p.sv - single-port byte-writable RAM with registered read
module nanorv32_sram_1p
    import nanorv32_datamem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic [3:0]                   we,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [NANORV32_DATA_MSB:0]   wdata,
    output logic [NANORV32_DATA_MSB:0]   rdata
);

    logic [NANORV32_DATA_MSB:0] mem [2**ADDR_WIDTH];

    // Read port only updates on pure reads so rdata keeps its last read value across writes.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (we == 4'b0000) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/nanorv32_datamem_responder.sv
// rtl/nanorv32_datamem_responder.sv - req/ack data memory responder with wait states and range check
module nanorv32_datamem_responder
    import nanorv32_datamem_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_datamem_req,
    input  logic [NANORV32_ADDR_MSB:0]   cpu_datamem_addr,
    input  logic [NANORV32_DATA_MSB:0]   cpu_datamem_wdata,
    input  logic [3:0]                   cpu_datamem_bytesel,
    output logic [NANORV32_DATA_MSB:0]   datamem_cpu_rdata,
    output logic                         datamem_cpu_ack,
    output logic                         datamem_err
);

    nanorv32_dmem_state_t           state;
    logic [NANORV32_DMEM_CNT_W-1:0] cnt;
    logic [NANORV32_ADDR_MSB:0]     addr_q;
    logic [NANORV32_DATA_MSB:0]     wdata_q;
    logic [3:0]                     bytesel_q;
    logic                           ack_q;
    logic                           err_q;
    logic                           rd_sel_q;
    logic [NANORV32_DATA_MSB:0]     rdata_hold;
    logic [NANORV32_DATA_MSB:0]     ram_q;
    logic [29:0]                    word_off;
    logic                           in_range;

    // Word offset from the base; any bit above the RAM index means out of range.
    assign word_off = addr_q[31:2] - BASE_ADDR[31:2];
    assign in_range = (addr_q >= BASE_ADDR) && (word_off[29:ADDR_WIDTH] == '0);

    nanorv32_sram_1p #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk   (clk),
        .en    ((state == NANORV32_DMEM_STATE_ACCESS) && in_range),
        .we    (bytesel_q),
        .addr  (word_off[ADDR_WIDTH-1:0]),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= NANORV32_DMEM_STATE_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            bytesel_q  <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_sel_q   <= 1'b0;
            rdata_hold <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                NANORV32_DMEM_STATE_IDLE: begin
                    if (cpu_datamem_req) begin
                        addr_q    <= cpu_datamem_addr;
                        wdata_q   <= cpu_datamem_wdata;
                        bytesel_q <= cpu_datamem_bytesel;
                        cnt       <= NANORV32_DMEM_CNT_W'(WAIT_STATES);
                        state     <= (WAIT_STATES > 0) ? NANORV32_DMEM_STATE_WAIT
                                                       : NANORV32_DMEM_STATE_ACCESS;
                    end
                end
                NANORV32_DMEM_STATE_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= 1) begin
                        state <= NANORV32_DMEM_STATE_ACCESS;
                    end
                end
                NANORV32_DMEM_STATE_ACCESS: begin
                    ack_q    <= 1'b1;
                    err_q    <= !in_range;
                    rd_sel_q <= in_range && (bytesel_q == 4'b0000);
                    state    <= NANORV32_DMEM_STATE_ACK;
                end
                NANORV32_DMEM_STATE_ACK: begin
                    err_q      <= 1'b0;
                    rd_sel_q   <= 1'b0;
                    rdata_hold <= datamem_cpu_rdata;
                    state      <= NANORV32_DMEM_STATE_IDLE;
                end
                default: state <= NANORV32_DMEM_STATE_IDLE;
            endcase
        end
    end

    // Output mux selects only between flops, so rdata still moves solely on the ACCESS->ACK edge.
    always_comb begin
        datamem_cpu_rdata = rdata_hold;
        if (ack_q) begin
            if (err_q) begin
                datamem_cpu_rdata = '0;
            end else if (rd_sel_q) begin
                datamem_cpu_rdata = ram_q;
            end
        end
    end

    assign datamem_cpu_ack = ack_q;
    assign datamem_err     = err_q;

endmodule

// File: tb/tb_nanorv32_datamem_responder.sv
// tb/tb_nanorv32_datamem_responder.sv - scoreboard bench over four wait-state configurations
module tb_nanorv32_datamem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bytesel;
    logic [31:0] rdata [4];
    logic [3:0]  ack;
    logic [3:0]  err;

    int checks;
    int failures;
    exp_t        sb[$];
    logic [31:0] mem_m [int];
    logic [31:0] last_rd [4];

    function automatic int ns_of(input int g);
        return (g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 5 : 2;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        nanorv32_datamem_responder #(
            .ADDR_WIDTH  (10),
            .BASE_ADDR   (32'h0000_0000),
            .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 5 : 2)
        ) u_dut (
            .clk                 (clk),
            .rst                 (rst),
            .cpu_datamem_req     (req[g]),
            .cpu_datamem_addr    (addr),
            .cpu_datamem_wdata   (wdata),
            .cpu_datamem_bytesel (bytesel),
            .datamem_cpu_rdata   (rdata[g]),
            .datamem_cpu_ack     (ack[g]),
            .datamem_err         (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic access(input int g, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] bs, input bit hold, input bit chg);
        exp_t        e;
        int          n;
        int          key;
        bit          seen;
        bit          extra;
        logic [31:0] m;
        @(negedge clk);
        addr = a; wdata = wd; bytesel = bs; req[g] = 1'b1;
        key = g * 65536 + int'(a[31:2]);
        if (a >= 32'h0000_1000) begin
            e.rdata = 32'h0; e.err = 1'b1;
        end else if (bs == 4'b0000) begin
            e.rdata = mem_m[key]; e.err = 1'b0;
        end else begin
            e.rdata = last_rd[g]; e.err = 1'b0;
            m = mem_m.exists(key) ? mem_m[key] : 32'h0;
            for (int i = 0; i < 4; i++) if (bs[i]) m[8*i +: 8] = wd[8*i +: 8];
            mem_m[key] = m;
        end
        last_rd[g] = e.rdata;
        e.lat = ns_of(g) + 2;
        sb.push_back(e);
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (chg && n == 1) addr = 32'h0000_0040;
            if (ack[g]) seen = 1'b1;
        end
        check("ack_seen", 32'(seen), 32'd1);
        e = sb.pop_front();
        check("latency", n, e.lat);
        check("rdata", rdata[g], e.rdata);
        check("err", 32'(err[g]), 32'(e.err));
        if (!hold) req[g] = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 32'(ack[g]), 32'd0);
        req[g] = 1'b0;
        if (hold) begin
            extra = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (ack[g]) extra = 1'b1;
            end
            check("no_second_ack", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int  cyc;
        bit  stray;
        checks = 0; failures = 0;
        rst = 1'b1; req = 4'b0; addr = 32'h0; wdata = 32'h0; bytesel = 4'h0;
        for (int i = 0; i < 4; i++) last_rd[i] = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("reset_ack", 32'(ack[i]), 32'd0);
            check("reset_err", 32'(err[i]), 32'd0);
            check("reset_rdata", rdata[i], 32'h0);
        end

        access(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
        access(0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);
        access(0, 32'h20, 32'h11223344, 4'hF, 1'b0, 1'b0);
        access(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0);
        access(0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0);
        check("lane_merge", rdata[0], 32'h11BB33DD);
        access(0, 32'h0, 32'h55AA55AA, 4'hF, 1'b0, 1'b0);
        access(0, 32'hFFC, 32'h0FFC0FFC, 4'hF, 1'b0, 1'b0);
        access(0, 32'hFFC, 32'h0, 4'h0, 1'b0, 1'b0);
        access(0, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0);
        access(0, 32'h1000, 32'h0, 4'h0, 1'b0, 1'b0);
        access(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);

        access(1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, 1'b0);
        access(1, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);

        access(3, 32'h30, 32'h30303030, 4'hF, 1'b0, 1'b0);
        access(3, 32'h40, 32'h40404040, 4'hF, 1'b0, 1'b0);
        access(3, 32'h30, 32'h0, 4'h0, 1'b0, 1'b1);

        access(2, 32'h8, 32'h12345678, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        addr = 32'h8; wdata = 32'hCAFEF00D; bytesel = 4'hF; req[2] = 1'b1;
        for (cyc = 0; cyc < 3; cyc++) @(negedge clk);
        rst = 1'b1; req[2] = 1'b0;
        #1;
        check("rst_mid_ack", 32'(ack[2]), 32'd0);
        check("rst_mid_rdata", rdata[2], 32'h0);
        for (int i = 0; i < 4; i++) last_rd[i] = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ack[2]) stray = 1'b1;
        end
        check("rst_no_ack", 32'(stray), 32'd0);
        access(2, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0);
        check("rst_old_value", rdata[2], 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
